// File: rtl/prefetch_fill_responder.sv
// Prefetch fill responder: queues prefetch line requests, drops duplicates,
// and returns each line as a fill after a fixed memory latency.
module prefetch_fill_responder #(
    parameter int block_size_byte = 16,
    parameter int mem_latency     = 4,
    parameter int queue_depth     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_address,
    output logic        req_ready,
    output logic        fill_valid,
    output logic [31:0] fill_address,
    input  logic        fill_ready,
    output logic [2:0]  pending_count,
    output logic [15:0] drop_count
);

    localparam int OFF_W  = $clog2(block_size_byte);
    localparam int LINE_W = 32 - OFF_W;
    localparam int PTR_W  = (queue_depth > 1) ? $clog2(queue_depth) : 1;
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(queue_depth - 1);
    localparam logic [2:0]       DEPTH_C  = 3'(queue_depth);
    localparam logic [7:0]       LAT_LOAD = 8'(mem_latency - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [7:0]        lat_cnt_reg, lat_cnt_next;
    logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [2:0]        count_reg;
    logic [15:0]       drop_reg;
    logic [31:0]       fill_addr_reg;
    logic [LINE_W-1:0] line_mem [queue_depth];
    logic [queue_depth-1:0] slot_vld_reg;
    logic [queue_depth-1:0] slot_hit;

    logic [LINE_W-1:0] req_line;
    logic [LINE_W-1:0] svc_line;
    logic [LINE_W-1:0] head_line;
    logic accept, dup, enq, pop, fill_done, fifo_nonempty;

    assign req_line      = req_address[31:OFF_W];
    assign svc_line      = fill_addr_reg[31:OFF_W];
    assign head_line     = line_mem[rd_ptr_reg];
    assign fifo_nonempty = (count_reg != 3'd0);

    assign req_ready = (count_reg < DEPTH_C);
    assign accept    = req_valid && req_ready;
    // The in-service line counts as present until its fill completes.
    assign dup       = (|slot_hit) || ((state_reg != ST_IDLE) && (svc_line == req_line));
    assign enq       = accept && !dup;
    assign fill_done = (state_reg == ST_RESP) && fill_ready;
    assign pop       = fifo_nonempty && ((state_reg == ST_IDLE) || fill_done);

    generate
        for (genvar gi = 0; gi < queue_depth; gi++) begin : g_slot
            assign slot_hit[gi] = slot_vld_reg[gi] && (line_mem[gi] == req_line);

            always_ff @(posedge clk) begin
                if (enq && (wr_ptr_reg == PTR_W'(gi))) begin
                    line_mem[gi] <= req_line;
                end
            end

            // A slot is never pushed and popped together: that needs a full
            // queue, where req_ready is already low.
            always_ff @(posedge clk) begin
                if (reset) begin
                    slot_vld_reg[gi] <= 1'b0;
                end else if (enq && (wr_ptr_reg == PTR_W'(gi))) begin
                    slot_vld_reg[gi] <= 1'b1;
                end else if (pop && (rd_ptr_reg == PTR_W'(gi))) begin
                    slot_vld_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        lat_cnt_next = lat_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pop) begin
                    state_next   = ST_WAIT;
                    lat_cnt_next = LAT_LOAD;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_reg == 8'd0) begin
                    state_next = ST_RESP;
                end else begin
                    lat_cnt_next = lat_cnt_reg - 8'd1;
                end
            end
            ST_RESP: begin
                if (fill_done) begin
                    if (pop) begin
                        state_next   = ST_WAIT;
                        lat_cnt_next = LAT_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next   = ST_IDLE;
                lat_cnt_next = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            lat_cnt_reg   <= 8'd0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= 3'd0;
            drop_reg      <= 16'd0;
            fill_addr_reg <= 32'd0;
        end else begin
            state_reg   <= state_next;
            lat_cnt_reg <= lat_cnt_next;
            if (enq) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_MAX) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg    <= (rd_ptr_reg == PTR_MAX) ? '0 : rd_ptr_reg + PTR_W'(1);
                fill_addr_reg <= 32'(head_line) << OFF_W;
            end
            case ({enq, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
            if (accept && dup && (drop_reg != 16'hFFFF)) begin
                drop_reg <= drop_reg + 16'd1;
            end
        end
    end

    assign fill_valid    = (state_reg == ST_RESP);
    assign fill_address  = fill_addr_reg;
    assign pending_count = count_reg;
    assign drop_count    = drop_reg;

endmodule

// File: tb/tb_prefetch_fill_responder.sv
// Directed bench for prefetch_fill_responder: a per-cycle vector table plus
// hand-written sequences for full-queue, stalled-fill and mid-service reset.
module tb_prefetch_fill_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_address;
    logic        req_ready;
    logic        fill_valid;
    logic [31:0] fill_address;
    logic        fill_ready;
    logic [2:0]  pending_count;
    logic [15:0] drop_count;

    prefetch_fill_responder #(
        .block_size_byte(16),
        .mem_latency    (4),
        .queue_depth    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_address  (req_address),
        .req_ready    (req_ready),
        .fill_valid   (fill_valid),
        .fill_address (fill_address),
        .fill_ready   (fill_ready),
        .pending_count(pending_count),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        logic        fr;
        logic        e_rdy;
        logic        e_fv;
        logic [31:0] e_fa;
        logic [2:0]  e_pend;
        logic [15:0] e_drop;
    } vec_t;

    localparam int NVEC = 35;
    vec_t tbl [NVEC];
    int n_vec = 0;
    int n_err = 0;

    function automatic vec_t mk(logic rv, logic [31:0] ra, logic fr, logic rdy,
                                logic fv, logic [31:0] fa, logic [2:0] pend,
                                logic [15:0] drop);
        vec_t v;
        v.rv = rv; v.ra = ra; v.fr = fr; v.e_rdy = rdy;
        v.e_fv = fv; v.e_fa = fa; v.e_pend = pend; v.e_drop = drop;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_q [$];
        logic [31:0] held_fa;
        int          n_fill;
        int          waited;
        bit          seen;

        // Cycle-by-cycle expectations with mem_latency=4, 16-byte lines.
        tbl[0]  = mk(0, 32'h0,        1, 1, 0, 32'h0,        0, 0);
        tbl[1]  = mk(1, 32'h00001234, 1, 1, 0, 32'h0,        0, 0);
        tbl[2]  = mk(0, 32'h0,        1, 1, 0, 32'h0,        1, 0);  // pop cycle
        for (int i = 3; i <= 6; i++) tbl[i] = mk(0, 32'h0, 1, 1, 0, 32'h00001230, 0, 0);
        tbl[7]  = mk(0, 32'h0,        1, 1, 1, 32'h00001230, 0, 0);  // pop + 5
        tbl[8]  = mk(0, 32'h0,        1, 1, 0, 32'h00001230, 0, 0);
        tbl[9]  = mk(1, 32'h00000100, 1, 1, 0, 32'h00001230, 0, 0);
        tbl[10] = mk(1, 32'h00000104, 1, 1, 0, 32'h00001230, 1, 0);  // duplicate line
        tbl[11] = mk(1, 32'h00000110, 1, 1, 0, 32'h00000100, 0, 1);
        for (int i = 12; i <= 14; i++) tbl[i] = mk(0, 32'h0, 1, 1, 0, 32'h00000100, 1, 1);
        tbl[15] = mk(0, 32'h0,        1, 1, 1, 32'h00000100, 1, 1);  // back-to-back pop
        for (int i = 16; i <= 19; i++) tbl[i] = mk(0, 32'h0, 1, 1, 0, 32'h00000110, 0, 1);
        tbl[20] = mk(0, 32'h0,        1, 1, 1, 32'h00000110, 0, 1);
        tbl[21] = mk(0, 32'h0,        1, 1, 0, 32'h00000110, 0, 1);
        tbl[22] = mk(1, 32'hFFFFFFFF, 1, 1, 0, 32'h00000110, 0, 1);
        tbl[23] = mk(1, 32'h00000200, 1, 1, 0, 32'h00000110, 1, 1);  // accept + pop
        for (int i = 24; i <= 27; i++) tbl[i] = mk(0, 32'h0, 1, 1, 0, 32'hFFFFFFF0, 1, 1);
        tbl[28] = mk(0, 32'h0,        1, 1, 1, 32'hFFFFFFF0, 1, 1);
        for (int i = 29; i <= 32; i++) tbl[i] = mk(0, 32'h0, 1, 1, 0, 32'h00000200, 0, 1);
        tbl[33] = mk(0, 32'h0,        1, 1, 1, 32'h00000200, 0, 1);
        tbl[34] = mk(0, 32'h0,        1, 1, 0, 32'h00000200, 0, 1);

        reset = 1'b1; req_valid = 1'b0; req_address = 32'h0; fill_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            req_valid   = tbl[i].rv;
            req_address = tbl[i].ra;
            fill_ready  = tbl[i].fr;
            @(negedge clk);
            $display("vec %0d: rv=%0b ra=%h rdy=%0b fv=%0b fa=%h pend=%0d drop=%0d",
                     i, tbl[i].rv, tbl[i].ra, req_ready, fill_valid, fill_address,
                     pending_count, drop_count);
            chk($sformatf("v%0d req_ready", i),     32'(req_ready),     32'(tbl[i].e_rdy));
            chk($sformatf("v%0d fill_valid", i),    32'(fill_valid),    32'(tbl[i].e_fv));
            chk($sformatf("v%0d fill_address", i),  fill_address,       tbl[i].e_fa);
            chk($sformatf("v%0d pending_count", i), 32'(pending_count), 32'(tbl[i].e_pend));
            chk($sformatf("v%0d drop_count", i),    32'(drop_count),    32'(tbl[i].e_drop));
            tick();
        end
        req_valid = 1'b0;

        // Stalled fill: held for 10 cycles, then exactly one handshake.
        fill_ready = 1'b0; req_valid = 1'b1; req_address = 32'h00003000;
        tick();
        req_valid = 1'b0;
        seen = 0;
        for (waited = 0; waited < 20; waited++) begin
            @(negedge clk);
            if (fill_valid) begin seen = 1; break; end
            tick();
        end
        chk("stall fill appears", 32'(seen), 32'd1);
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d fill_valid", k), 32'(fill_valid), 32'd1);
            chk($sformatf("stall%0d fill_address", k), fill_address, 32'h00003000);
            tick();
        end
        fill_ready = 1'b1;
        n_fill = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (fill_valid && fill_ready) n_fill++;
            tick();
        end
        $display("stall: fills counted %0d", n_fill);
        chk("stall fill count", 32'(n_fill), 32'd1);

        // Full queue: 5 distinct requests, 6th waits for the first fill.
        fill_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            req_valid = 1'b1; req_address = 32'(i) << 12;
            @(negedge clk);
            chk($sformatf("full req%0d ready", i), 32'(req_ready), 32'd1);
            tick();
        end
        req_address = 32'h00006000;
        @(negedge clk);
        chk("full pending", 32'(pending_count), 32'd4);
        chk("full ready low", 32'(req_ready), 32'd0);
        tick();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("full wait%0d ready", k), 32'(req_ready), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("full head fill_valid", 32'(fill_valid), 32'd1);
        chk("full head fill_address", fill_address, 32'h00001000);
        chk("full ready on fill cycle", 32'(req_ready), 32'd0);
        fill_ready = 1'b1;
        tick();
        fill_ready = 1'b0;
        @(negedge clk);
        chk("sixth req ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("sixth req queued", 32'(pending_count), 32'd4);
        exp_q = '{32'h00002000, 32'h00003000, 32'h00004000, 32'h00005000, 32'h00006000};
        fill_ready = 1'b1;
        n_fill = 0;
        for (waited = 0; waited < 100 && n_fill < 5; waited++) begin
            @(negedge clk);
            if (fill_valid) begin
                $display("drain fill %0d: %h", n_fill, fill_address);
                chk($sformatf("drain fill%0d", n_fill), fill_address, exp_q[n_fill]);
                n_fill++;
            end
            tick();
        end
        chk("drain fill total", 32'(n_fill), 32'd5);

        // Reset while in WAIT abandons the request.
        req_valid = 1'b1; req_address = 32'h00007000;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1; req_valid = 1'b1; req_address = 32'h00008000;
        tick();
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("post-reset req_ready", 32'(req_ready), 32'd1);
        chk("post-reset pending", 32'(pending_count), 32'd0);
        chk("post-reset drop", 32'(drop_count), 32'd0);
        chk("post-reset fill_address", fill_address, 32'h0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (fill_valid) seen = 1;
            tick();
        end
        chk("post-reset no fill", 32'(seen), 32'd0);
        req_valid = 1'b1; req_address = 32'h0000900C;
        tick();
        req_valid = 1'b0;
        seen = 0;
        for (waited = 0; waited < 20; waited++) begin
            @(negedge clk);
            if (fill_valid) begin seen = 1; break; end
            tick();
        end
        $display("post-reset fill seen=%0b addr=%h", seen, fill_address);
        chk("post-reset fill appears", 32'(seen), 32'd1);
        chk("post-reset fill_address", fill_address, 32'h00009000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
